// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared FSM state type and result-width helper for the BCD-to-binary converter
package bcd2bin_pkg;
  typedef enum logic [1:0] {IDLE, OP, DONE, ERR} state_t;
  function automatic int bin_w(input int ndig);
    longint m = 1;
    int w = 0;
    for (int i = 0; i < ndig; i++) m = m * 10;
    m = m - 1;
    for (int i = 0; i < 63; i++) if ((m >> i) != 0) w = i + 1;
    return w;
  endfunction
endpackage

// File: rtl/bcd2bin_digit_adj.sv
// bcd2bin_digit_adj: subtracts 3 from a BCD digit that reached 8 or more after a right shift
module bcd2bin_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd8) ? d_i - 4'd3 : d_i;
endmodule

// File: rtl/bcd2bin_multi.sv
// bcd2bin_multi: sequential NDIG-digit BCD to binary converter (reverse double dabble, BIN_W shifts)
module bcd2bin_multi import bcd2bin_pkg::*; #(
  parameter int NDIG = 2,
  localparam int BIN_W = bin_w(NDIG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [4*NDIG-1:0] bcd,
  output logic              ready,
  output logic              done_tick,
  output logic              err_tick,
  output logic [BIN_W-1:0]  bin
);
  localparam int CW = $clog2(BIN_W + 1);
  state_t state_q, state_d;
  logic [4*NDIG-1:0] dig_q, dig_d, dig_sh, dig_adj;
  logic [BIN_W-1:0] acc_q, acc_d, acc_sh, bin_q, bin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4*NDIG+BIN_W-1:0] sh;
  logic bad;
  assign sh = {dig_q, acc_q} >> 1;
  assign dig_sh = sh[4*NDIG+BIN_W-1:BIN_W];
  assign acc_sh = sh[BIN_W-1:0];
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd2bin_digit_adj u_adj (.d_i(dig_sh[4*g+:4]), .d_o(dig_adj[4*g+:4]));
  end
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) bad = bad | (bcd[4*i+:4] > 4'd9);
  end
  always_comb begin
    state_d = state_q;
    dig_d = dig_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        if (bad) state_d = ERR;
        else begin
          state_d = OP;
          dig_d = bcd;
          acc_d = '0;
          cnt_d = CW'(BIN_W);
        end
      end
      OP: if (abort) state_d = IDLE;
      else begin
        dig_d = dig_adj;
        acc_d = acc_sh;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bin_d = acc_sh;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dig_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      bin_q <= '0;
    end else begin
      state_q <= state_d;
      dig_q <= dig_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
    end
  end
  assign ready = state_q == IDLE;
  assign done_tick = state_q == DONE;
  assign err_tick = state_q == ERR;
  assign bin = bin_q;
endmodule

// File: tb/tb_bcd2bin_multi.sv
// tb_bcd2bin_multi: directed and random checks of bcd2bin_multi for NDIG = 1, 2, 3, 4 and 8
module tb_bcd2bin_multi;
  logic clk, reset_n;
  logic [31:0] bcd_v;
  logic start_v[5], abort_v[5], rdy[5], dn[5], er[5];
  logic [26:0] bin_a[5];
  logic [3:0] b1;
  logic [6:0] b2;
  logic [9:0] b3;
  logic [13:0] b4;
  logic [26:0] b8;
  int checks = 0, failures = 0;
  assign bin_a[0] = 27'(b1);
  assign bin_a[1] = 27'(b2);
  assign bin_a[2] = 27'(b3);
  assign bin_a[3] = 27'(b4);
  assign bin_a[4] = b8;
  bcd2bin_multi #(.NDIG(1)) u1 (.clk(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]),
    .bcd(bcd_v[3:0]), .ready(rdy[0]), .done_tick(dn[0]), .err_tick(er[0]), .bin(b1));
  bcd2bin_multi #(.NDIG(2)) u2 (.clk(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]),
    .bcd(bcd_v[7:0]), .ready(rdy[1]), .done_tick(dn[1]), .err_tick(er[1]), .bin(b2));
  bcd2bin_multi #(.NDIG(3)) u3 (.clk(clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort_v[2]),
    .bcd(bcd_v[11:0]), .ready(rdy[2]), .done_tick(dn[2]), .err_tick(er[2]), .bin(b3));
  bcd2bin_multi #(.NDIG(4)) u4 (.clk(clk), .reset_n(reset_n), .start(start_v[3]), .abort(abort_v[3]),
    .bcd(bcd_v[15:0]), .ready(rdy[3]), .done_tick(dn[3]), .err_tick(er[3]), .bin(b4));
  bcd2bin_multi #(.NDIG(8)) u8 (.clk(clk), .reset_n(reset_n), .start(start_v[4]), .abort(abort_v[4]),
    .bcd(bcd_v), .ready(rdy[4]), .done_tick(dn[4]), .err_tick(er[4]), .bin(b8));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic longint dec(input logic [31:0] v, input int n);
    longint r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i+:4]);
    return r;
  endfunction
  task automatic conv(input int s, input logic [31:0] v, input longint exp, input int bw, input bit hold);
    int lat = 0;
    chk("ready_before", rdy[s], 1);
    bcd_v = v;
    start_v[s] = 1'b1;
    step();
    if (!hold) start_v[s] = 1'b0;
    chk("accepted", rdy[s], 0);
    while (!dn[s] && lat < 60) begin
      step();
      lat++;
    end
    chk("latency", lat, bw);
    chk("bin", bin_a[s], exp);
    step();
    chk("done_one_cycle", dn[s], 0);
    chk("ready_after", rdy[s], 1);
  endtask
  task automatic errchk(input int s, input logic [31:0] v, input longint prev);
    bcd_v = v;
    start_v[s] = 1'b1;
    step();
    start_v[s] = 1'b0;
    chk("err_tick", er[s], 1);
    chk("err_no_done", dn[s], 0);
    step();
    chk("err_one_cycle", er[s], 0);
    chk("err_ready", rdy[s], 1);
    chk("err_bin_kept", bin_a[s], prev);
  endtask
  initial begin
    int ticks;
    logic [31:0] v;
    reset_n = 1'b0;
    bcd_v = '0;
    for (int i = 0; i < 5; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    #12;
    chk("rst_ready", rdy[1], 1);
    chk("rst_done", dn[1], 0);
    chk("rst_err", er[4], 0);
    chk("rst_bin", bin_a[4], 0);
    step();
    reset_n = 1'b1;
    conv(1, 32'h99, 99, 7, 0);
    errchk(1, 32'h3A, 99);
    conv(3, 32'h9999, 9999, 14, 1);
    conv(3, 32'h0000, 0, 14, 0);
    bcd_v = 32'h42;
    start_v[1] = 1'b1;
    step();
    step();
    step();
    abort_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    abort_v[1] = 1'b0;
    chk("abort_ready", rdy[1], 1);
    chk("abort_no_done", dn[1], 0);
    chk("abort_bin_kept", bin_a[1], 99);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      ticks += int'(dn[1]) + int'(!rdy[1]);
    end
    chk("abort_no_queue", ticks, 0);
    start_v[1] = 1'b1;
    abort_v[1] = 1'b1;
    step();
    chk("abort_wins_idle", rdy[1], 1);
    start_v[1] = 1'b0;
    abort_v[1] = 1'b0;
    conv(2, 32'h123, 123, 10, 0);
    bcd_v = 32'h567;
    start_v[2] = 1'b1;
    step();
    start_v[2] = 1'b0;
    step();
    step();
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_bin", bin_a[2], 0);
    chk("midrst_ready", rdy[2], 1);
    step();
    reset_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      ticks += int'(dn[2]) + int'(er[2]);
    end
    chk("midrst_no_tick", ticks, 0);
    conv(2, 32'h567, 567, 10, 0);
    for (int i = 0; i < 10; i++) conv(0, 32'(i), i, 4, 0);
    for (int i = 10; i < 16; i++) errchk(0, 32'(i), 9);
    conv(4, 32'h99999999, 99999999, 27, 0);
    conv(4, 32'h00000000, 0, 27, 0);
    for (int k = 0; k < 1000; k++) begin
      for (int d = 0; d < 8; d++) v[4*d+:4] = 4'($urandom_range(0, 9));
      conv(4, v, dec(v, 8), 27, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd2bin_multi.md
BCD2BIN_MULTI -- requirements
Module: bcd2bin_multi

Interface
REQ-001 SHALL have parameter NDIG, default 2: number of BCD digits, legal range 1..8.
REQ-002 SHALL have derived localparam BIN_W, the minimum bits holding 10^NDIG-1: 4, 7, 10, 14, 17, 20, 24, 27 for NDIG 1..8.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  conversion request, sampled only when ready=1.
REQ-006 SHALL have port abort  input  1  cancel an in-flight conversion.
REQ-007 SHALL have port bcd  input  4*NDIG  packed digits; digit 0 (least significant) at bits [3:0].
REQ-008 SHALL have port ready  output  1  high in IDLE only.
REQ-009 SHALL have port done_tick  output  1  one-cycle pulse, bin holds a new valid result.
REQ-010 SHALL have port err_tick  output  1  one-cycle pulse, request rejected for an illegal digit.
REQ-011 SHALL have port bin  output  BIN_W  registered binary result.

Function
REQ-012 SHALL implement FSM states IDLE, OP, DONE and ERR; outputs ready, done_tick and err_tick are Moore-decoded from the state (IDLE, DONE and ERR respectively).
REQ-013 SHALL, on the edge where start=1 and ready=1 (acceptance edge E0), check the digits: if any digit > 9, go to ERR; otherwise go to OP and load the digits into the internal shift register, clear the binary accumulator and load the iteration counter with BIN_W.
REQ-014 SHALL, on each OP edge, shift {digits, accumulator} right one bit, then subtract 3 from every 4-bit digit whose value is >= 8, and decrement the counter.
REQ-015 SHALL, on the OP edge where the counter reaches 0 (edge E0+BIN_W), copy the accumulator into bin and enter DONE; bin therefore changes only on that edge.
REQ-016 SHALL assert done_tick during the cycle after E0+BIN_W; the FSM returns to IDLE at E0+BIN_W+1.
REQ-017 SHALL, in ERR, hold err_tick high for exactly one cycle, leave bin unchanged, never assert done_tick, and return to IDLE on the next edge.
REQ-018 SHALL ignore start while ready=0; no request is queued.
REQ-019 SHALL treat abort=1 on any OP edge (including the final one) as returning to IDLE with no done_tick and bin unchanged.
REQ-020 SHALL ignore abort in IDLE, DONE and ERR; when start and abort are both high in IDLE, abort wins and start is ignored.
REQ-021 SHALL compute bin as the exact decimal value of bcd for every legal input, 0 through 10^NDIG-1, with no overflow.
REQ-022 SHALL allow back-to-back requests: start held high is accepted again on the edge after DONE returns to IDLE.

Reset
REQ-023 SHALL, while reset_n=0, asynchronously force state IDLE, bin=0, counter=0 and shift register=0; outputs during reset are ready=1, done_tick=0, err_tick=0.
REQ-024 SHALL discard any conversion in progress when reset is asserted mid-operation, with no done_tick or err_tick after release.
REQ-025 SHALL make the first acceptance possible on the first rising edge after reset_n deasserts.

Structure
REQ-026 SHALL place the state enumeration and the NDIG-to-BIN_W lookup function in shared package bcd2bin_pkg.
REQ-027 SHALL implement the per-digit conditional subtract-3 as sub-module bcd2bin_digit_adj, instantiated NDIG times through a generate loop.
REQ-028 SHALL contain no combinational path from any input to any output.

Verification
REQ-029 NDIG=2: bcd=8'h99, start pulse -> bin=99 (7'h63); done_tick high for one cycle exactly 7 cycles after acceptance; ready returns the following cycle.
REQ-030 NDIG=2: bcd=8'h3A, start -> err_tick for one cycle; bin keeps its previous value; done_tick never asserted.
REQ-031 NDIG=4: bcd=16'h9999 then 16'h0000, start held high -> bin=9999 then 0; the second acceptance occurs on the edge after the first DONE.
REQ-032 NDIG=2: bcd=8'h42, abort asserted on the 3rd OP cycle -> no done_tick, bin unchanged, ready=1 on the next cycle; start during OP is ignored.
REQ-033 NDIG=3: reset_n pulled low mid-OP with bcd=12'h567 -> bin=0 and ready=1 immediately; no tick after release; a new request for 12'h567 yields bin=567.
REQ-034 NDIG=1 and NDIG=8: exhaustive (NDIG=1) and random (NDIG=8, >=1000 values incl. 99999999) legal inputs -> bin equals the reference decimal value and latency equals BIN_W in every case.
